text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
- Parametrised character-stream writer for the text-mode video RAM.
- Accepts one ASCII byte per cycle over a valid/ready handshake and tracks the cursor.
- Interprets LF, CR and BS, and issues single-cycle writes of {row, col} address plus data to the character buffer.
- On overflow it either hardware-scrolls, with a scroll-offset output consumed by the VGA scan-out, or wraps to the top; the recycled line is blanked in both cases.

Parameters:
- COLS, 80, characters per line.
- ROWS, 30, lines per screen.
- SCROLL_MODE, 1, 1 = scroll on overflow; 0 = wrap to physical row 0 and pulse o_full.
- FILL_CHAR, 8'h20, byte written when clearing cells.
- Derived localparams: COL_W = $clog2(COLS), ROW_W = $clog2(ROWS), ADDR_W = ROW_W + COL_W.

Ports:
- i_clk, input, 1, system clock.
- i_rst_n, input, 1, reset, asynchronous, active-low.
- i_valid, input, 1, i_data holds a byte to consume.
- i_data, input, 8, ASCII byte.
- o_ready, output, 1, block can accept a byte this cycle.
- i_clear, input, 1, request a full-screen clear and cursor home.
- o_address, output, ADDR_W, video RAM address {phys_row, col}.
- o_data, output, 8, video RAM write data.
- o_we, output, 1, video RAM write enable.
- o_scroll, output, ROW_W, physical row displayed as the top line.
- o_cur_col, output, COL_W, cursor column.
- o_cur_row, output, ROW_W, cursor physical row.
- o_full, output, 1, one-cycle pulse on wrap (SCROLL_MODE=0 only).

Behaviour:
- Reset (i_rst_n low, async):
  - o_we=0, o_address=0, o_data=0, o_scroll=0, o_cur_col=0, o_cur_row=0, o_full=0, o_ready=0.
  - State is CLEAR_ALL.
- States:
  - IDLE: o_ready=1.
  - CLEAR_ALL: o_ready=0. Takes ROWS*COLS cycles, writes FILL_CHAR row-major from {0,0} to {ROWS-1,COLS-1} with o_we=1 every cycle, then goes to IDLE.
  - CLEAR_LINE: o_ready=0. Takes COLS cycles, writes FILL_CHAR to {cur_row, 0..COLS-1}, then goes to IDLE.
- o_ready = (state == IDLE), combinational from the state register. A byte is accepted when i_valid && o_ready.
- All write outputs are registered. A byte accepted in cycle N produces o_we/o_address/o_data in cycle N+1. o_we=0 in every cycle with no write.
- Byte decode in IDLE:
  - 0x20..0x7E: write at {cur_row, cur_col}. If cur_col == COLS-1, perform NEWLINE; else cur_col += 1.
  - 0x0A (LF): no write; perform NEWLINE.
  - 0x0D (CR): no write; cur_col = 0.
  - 0x08 (BS): if cur_col > 0, cur_col -= 1 and write FILL_CHAR at the new column; at column 0 it is ignored (no write, no row change).
  - Any other byte: consumed and dropped, no write.
- NEWLINE:
  - Always sets cur_col = 0.
  - If cur_row != (o_scroll + ROWS-1) mod ROWS: cur_row = (cur_row+1) mod ROWS.
  - Else, if SCROLL_MODE=1: o_scroll = (o_scroll+1) mod ROWS, cur_row = old o_scroll, go to CLEAR_LINE.
  - Else (SCROLL_MODE=0): cur_row = (cur_row+1) mod ROWS, o_full=1 for one cycle, go to CLEAR_LINE.
- A printable character at the last column is written first; the NEWLINE-triggered CLEAR_LINE starts the following cycle.
- i_clear, in any state:
  - Next cycle: cursor = {0,0}, o_scroll = 0, state = CLEAR_ALL (restarting it if already active).
  - Has priority over a same-cycle accepted byte; that byte is consumed and discarded.
- All row/column arithmetic is modulo ROWS/COLS. No address ever exceeds {ROWS-1, COLS-1}, including when ROWS or COLS is not a power of two.
- o_cur_col and o_cur_row always reflect the position of the next printable write.

Decomposition:
- Shared package `console_pkg`:
  - state enum (IDLE, CLEAR_ALL, CLEAR_LINE);
  - ASCII constants CHR_LF=8'h0A, CHR_CR=8'h0D, CHR_BS=8'h08, CHR_SP=8'h20;
  - function is_printable.
- One natural sub-module, `console_cursor`:
  - holds cur_row/cur_col/scroll registers and the modulo-increment logic;
  - advance/newline/home/backspace strobes in, flag indicating "at bottom line" out.
- The top level keeps the FSM, the clear counters and the write-port registers.

Test Plan:
- Reset, then hold i_valid=0 → o_ready=0 for exactly 2400 cycles with o_we=1 and addresses {0,0}..{29,79} row-major, data 0x20; o_ready=1 on cycle 2401.
- Send "AB", CR, "C" → writes 'A'@{0,0}, 'B'@{0,1}, 'C'@{0,0}; final cursor {0,1}.
- Send 81 × 'x' → 80 writes on row 0, the 81st at {1,0}; BS then produces a write of 0x20 at {1,0} with cursor {1,0}; a second BS produces no write.
- SCROLL_MODE=1, 30 × LF from {0,0} → after the 30th LF o_scroll=1, cur_row=0, o_ready low for 80 cycles while writing 0x20 to {0,0..79}.
- SCROLL_MODE=0, same stimulus → o_scroll stays 0, o_full pulses once, cur_row=0, row 0 cleared.
- Hold i_valid=1 with 'Z' during CLEAR_LINE, then assert i_clear in the same cycle 'Z' is accepted → 'Z' never written, full clear restarts at {0,0}, o_scroll=0.

Source files
------------

// File: rtl/text_console_writer_pkg.sv
// rtl/text_console_writer_pkg.sv - shared types and ASCII constants for the console writer
package console_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLEAR_ALL  = 2'd1,
        CLEAR_LINE = 2'd2
    } state_t;

    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_BS = 8'h08;
    localparam logic [7:0] CHR_SP = 8'h20;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CHR_SP) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// rtl/text_console_writer_if.sv - byte stream in and video RAM write port out
interface text_console_writer_if #(
    parameter int ADDR_W = 12
) ();
    logic              i_valid;
    logic [7:0]        i_data;
    logic              o_ready;
    logic [ADDR_W-1:0] o_address;
    logic [7:0]        o_data;
    logic              o_we;

    modport slave (
        input  i_valid, i_data,
        output o_ready, o_address, o_data, o_we
    );

    modport master (
        output i_valid, i_data,
        input  o_ready, o_address, o_data, o_we
    );
endinterface

// File: rtl/text_console_writer_cursor.sv
// rtl/text_console_writer_cursor.sv - cursor and scroll-offset registers with modulo stepping
module console_cursor #(
    parameter int  COLS        = 80,
    parameter int  ROWS        = 30,
    parameter int  SCROLL_MODE = 1,
    localparam int COL_W       = $clog2(COLS),
    localparam int ROW_W       = $clog2(ROWS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_home,
    input  logic             i_advance,
    input  logic             i_newline,
    input  logic             i_carriage,
    input  logic             i_backspace,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_scroll,
    output logic             o_at_bottom
);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] scroll_q;
    logic [ROW_W-1:0] bottom_row;

    function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
        return (r == LAST_ROW) ? '0 : r + 1'b1;
    endfunction

    // The bottom visible line sits just above the top line in the circular buffer.
    assign bottom_row  = (scroll_q == '0) ? LAST_ROW : scroll_q - 1'b1;
    assign o_at_bottom = (row_q == bottom_row);
    assign o_row       = row_q;
    assign o_col       = col_q;
    assign o_scroll    = scroll_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_q    <= '0;
            col_q    <= '0;
            scroll_q <= '0;
        end else if (i_home) begin
            row_q    <= '0;
            col_q    <= '0;
            scroll_q <= '0;
        end else if (i_newline) begin
            col_q <= '0;
            if (!o_at_bottom || SCROLL_MODE == 0) begin
                row_q <= row_inc(row_q);
            end else begin
                scroll_q <= row_inc(scroll_q);
                row_q    <= scroll_q;
            end
        end else if (i_advance) begin
            col_q <= (col_q == LAST_COL) ? '0 : col_q + 1'b1;
        end else if (i_carriage) begin
            col_q <= '0;
        end else if (i_backspace && col_q != '0) begin
            col_q <= col_q - 1'b1;
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - character stream to text-mode video RAM writer with scroll/wrap
module text_console_writer
    import console_pkg::*;
#(
    parameter int          COLS        = 80,
    parameter int          ROWS        = 30,
    parameter int          SCROLL_MODE = 1,
    parameter logic [7:0]  FILL_CHAR   = 8'h20,
    localparam int         COL_W       = $clog2(COLS),
    localparam int         ROW_W       = $clog2(ROWS),
    localparam int         ADDR_W      = ROW_W + COL_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    text_console_writer_if.slave bus,
    input  logic                 i_clear,
    output logic [ROW_W-1:0]     o_scroll,
    output logic [COL_W-1:0]     o_cur_col,
    output logic [ROW_W-1:0]     o_cur_row,
    output logic                 o_full
);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  clr_row_q, clr_row_d;
    logic [COL_W-1:0]  clr_col_q, clr_col_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              full_q, full_d;

    logic              home, advance, newline, carriage, backspace;
    logic [ROW_W-1:0]  cur_row, scroll;
    logic [COL_W-1:0]  cur_col;
    logic              at_bottom;

    console_cursor #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .SCROLL_MODE (SCROLL_MODE)
    ) u_cursor (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_home      (home),
        .i_advance   (advance),
        .i_newline   (newline),
        .i_carriage  (carriage),
        .i_backspace (backspace),
        .o_row       (cur_row),
        .o_col       (cur_col),
        .o_scroll    (scroll),
        .o_at_bottom (at_bottom)
    );

    assign bus.o_ready   = (state_q == IDLE);
    assign bus.o_we      = we_q;
    assign bus.o_address = addr_q;
    assign bus.o_data    = data_q;
    assign o_scroll      = scroll;
    assign o_cur_col     = cur_col;
    assign o_cur_row     = cur_row;
    assign o_full        = full_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= CLEAR_ALL;
            clr_row_q <= '0;
            clr_col_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_row_q <= clr_row_d;
            clr_col_q <= clr_col_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            full_q    <= full_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_row_d = clr_row_q;
        clr_col_d = clr_col_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        full_d    = 1'b0;
        home      = 1'b0;
        advance   = 1'b0;
        newline   = 1'b0;
        carriage  = 1'b0;
        backspace = 1'b0;

        if (i_clear) begin
            // A clear wins over everything, including a byte accepted this cycle.
            state_d   = CLEAR_ALL;
            clr_row_d = '0;
            clr_col_d = '0;
            home      = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        if (is_printable(bus.i_data)) begin
                            we_d   = 1'b1;
                            addr_d = {cur_row, cur_col};
                            data_d = bus.i_data;
                            if (cur_col == LAST_COL) newline = 1'b1;
                            else                     advance = 1'b1;
                        end else if (bus.i_data == CHR_LF) begin
                            newline = 1'b1;
                        end else if (bus.i_data == CHR_CR) begin
                            carriage = 1'b1;
                        end else if (bus.i_data == CHR_BS && cur_col != '0) begin
                            backspace = 1'b1;
                            we_d      = 1'b1;
                            addr_d    = {cur_row, cur_col - 1'b1};
                            data_d    = FILL_CHAR;
                        end
                        if (newline && at_bottom) begin
                            state_d   = CLEAR_LINE;
                            clr_col_d = '0;
                            full_d    = (SCROLL_MODE == 0);
                        end
                    end
                end
                CLEAR_ALL: begin
                    we_d   = 1'b1;
                    addr_d = {clr_row_q, clr_col_q};
                    data_d = FILL_CHAR;
                    if (clr_col_q == LAST_COL) begin
                        clr_col_d = '0;
                        if (clr_row_q == LAST_ROW) state_d = IDLE;
                        else                       clr_row_d = clr_row_q + 1'b1;
                    end else begin
                        clr_col_d = clr_col_q + 1'b1;
                    end
                end
                CLEAR_LINE: begin
                    // The cursor already points at the recycled line and stays put here.
                    we_d   = 1'b1;
                    addr_d = {cur_row, clr_col_q};
                    data_d = FILL_CHAR;
                    if (clr_col_q == LAST_COL) state_d = IDLE;
                    else                       clr_col_d = clr_col_q + 1'b1;
                end
                default: state_d = CLEAR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// tb/tb_text_console_writer.sv - self-checking bench for text_console_writer
module tb_text_console_writer;
    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld;
    logic [7:0] dat;
    logic       clr;
    logic [4:0] scr_s, row_s, scr_w, row_w;
    logic [6:0] col_s, col_w;
    logic       full_s, full_w;

    int n_checks = 0;
    int n_fail   = 0;

    text_console_writer_if #(.ADDR_W(12)) bus_s ();
    text_console_writer_if #(.ADDR_W(12)) bus_w ();

    assign bus_s.i_valid = vld;
    assign bus_s.i_data  = dat;
    assign bus_w.i_valid = vld;
    assign bus_w.i_data  = dat;

    text_console_writer #(.COLS(COLS), .ROWS(ROWS), .SCROLL_MODE(1)) u_scr (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_s.slave), .i_clear(clr),
        .o_scroll(scr_s), .o_cur_col(col_s), .o_cur_row(row_s), .o_full(full_s));

    text_console_writer #(.COLS(COLS), .ROWS(ROWS), .SCROLL_MODE(0)) u_wrp (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_w.slave), .i_clear(clr),
        .o_scroll(scr_w), .o_cur_col(col_w), .o_cur_row(row_w), .o_full(full_w));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference model: index 0 scrolls, index 1 wraps. kind 0 idle, 1 full clear, 2 line clear.
    int         m_kind[2], m_k[2], m_row[2], m_col[2], m_scr[2];
    bit         e_we[2], e_full[2];
    int         e_row[2], e_col[2];
    logic [7:0] e_data[2];

    int         wr_s, wr_w, full_cnt_w, full_cnt_s;
    logic [11:0] last_addr_s;
    bit         zwatch, zseen;

    function automatic void model_reset(input int i);
        m_kind[i] = 1; m_k[i] = 0;
        m_row[i] = 0; m_col[i] = 0; m_scr[i] = 0;
        e_we[i] = 0; e_full[i] = 0;
    endfunction

    function automatic void model_step(input int i, input int mode);
        bit nl;
        int bot, old;
        e_we[i] = 0; e_full[i] = 0; nl = 0;
        if (clr) begin
            m_row[i] = 0; m_col[i] = 0; m_scr[i] = 0;
            m_kind[i] = 1; m_k[i] = 0;
            return;
        end
        if (m_kind[i] == 1) begin
            e_we[i] = 1; e_row[i] = m_k[i] / COLS; e_col[i] = m_k[i] % COLS; e_data[i] = 8'h20;
            m_k[i]++;
            if (m_k[i] == ROWS * COLS) m_kind[i] = 0;
        end else if (m_kind[i] == 2) begin
            e_we[i] = 1; e_row[i] = m_row[i]; e_col[i] = m_k[i]; e_data[i] = 8'h20;
            m_k[i]++;
            if (m_k[i] == COLS) m_kind[i] = 0;
        end else if (vld) begin
            if (dat >= 8'h20 && dat <= 8'h7E) begin
                e_we[i] = 1; e_row[i] = m_row[i]; e_col[i] = m_col[i]; e_data[i] = dat;
                if (m_col[i] == COLS - 1) nl = 1;
                else m_col[i]++;
            end else if (dat == 8'h0A) begin
                nl = 1;
            end else if (dat == 8'h0D) begin
                m_col[i] = 0;
            end else if (dat == 8'h08 && m_col[i] > 0) begin
                m_col[i]--;
                e_we[i] = 1; e_row[i] = m_row[i]; e_col[i] = m_col[i]; e_data[i] = 8'h20;
            end
            if (nl) begin
                m_col[i] = 0;
                bot = (m_scr[i] + ROWS - 1) % ROWS;
                if (m_row[i] != bot) begin
                    m_row[i] = (m_row[i] + 1) % ROWS;
                end else begin
                    if (mode == 1) begin
                        old = m_scr[i];
                        m_scr[i] = (m_scr[i] + 1) % ROWS;
                        m_row[i] = old;
                    end else begin
                        m_row[i] = (m_row[i] + 1) % ROWS;
                        e_full[i] = 1;
                    end
                    m_kind[i] = 2; m_k[i] = 0;
                end
            end
        end
    endfunction

    task automatic chk(input int i, input string nm, input logic we, input logic [11:0] addr,
                       input logic [7:0] d, input logic rdy, input logic [4:0] scr,
                       input logic [4:0] row, input logic [6:0] col, input logic full);
        bit ok;
        logic [11:0] ea;
        ea = {5'(e_row[i]), 7'(e_col[i])};
        ok = (we == e_we[i]) && (!e_we[i] || (addr == ea && d == e_data[i])) &&
             (rdy == (m_kind[i] == 0)) && (scr == 5'(m_scr[i])) &&
             (row == 5'(m_row[i])) && (col == 7'(m_col[i])) && (full == e_full[i]);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s t=%0t got we=%b addr=%h data=%h rdy=%b scr=%0d cur=%0d,%0d full=%b exp we=%b addr=%h data=%h rdy=%b scr=%0d cur=%0d,%0d full=%b",
                     nm, $time, we, addr, d, rdy, scr, row, col, full,
                     e_we[i], ea, e_data[i], m_kind[i] == 0, m_scr[i], m_row[i], m_col[i], e_full[i]);
        end
    endtask

    task automatic expect_eq(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic c);
        vld = v; dat = d; clr = c;
    endtask

    task automatic tick();
        model_step(0, 1);
        model_step(1, 0);
        @(posedge clk);
        #1;
        chk(0, "scroll_cycle", bus_s.o_we, bus_s.o_address, bus_s.o_data, bus_s.o_ready,
            scr_s, row_s, col_s, full_s);
        chk(1, "wrap_cycle", bus_w.o_we, bus_w.o_address, bus_w.o_data, bus_w.o_ready,
            scr_w, row_w, col_w, full_w);
        if (bus_s.o_we) begin wr_s++; last_addr_s = bus_s.o_address; end
        if (bus_w.o_we) wr_w++;
        if (full_w) full_cnt_w++;
        if (full_s) full_cnt_s++;
        if (zwatch && bus_s.o_we && bus_s.o_data == 8'h5A) zseen = 1;
    endtask

    task automatic wait_ready(input string nm, output int low);
        int guard;
        low = 0; guard = 0;
        while (!bus_s.o_ready && guard < 3000) begin
            low++; guard++;
            tick();
        end
        if (!bus_s.o_ready) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout got ready=0 exp ready=1", nm);
        end
    endtask

    task automatic do_clear();
        int low;
        drive(0, 8'h00, 1);
        tick();
        drive(0, 8'h00, 0);
        wait_ready("clear_wait", low);
    endtask

    typedef struct {
        logic [7:0] d;
        bit         we;
        int         row, col;
        logic [7:0] wd;
        int         cr, cc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int low;
        vecs[0] = '{8'h41, 1, 0, 0, 8'h41, 0, 1};
        vecs[1] = '{8'h42, 1, 0, 1, 8'h42, 0, 2};
        vecs[2] = '{8'h0D, 0, 0, 0, 8'h00, 0, 0};
        vecs[3] = '{8'h43, 1, 0, 0, 8'h43, 0, 1};
        vecs[4] = '{8'h07, 0, 0, 0, 8'h00, 0, 1};
        vecs[5] = '{8'h08, 1, 0, 0, 8'h20, 0, 0};
        vecs[6] = '{8'h08, 0, 0, 0, 8'h00, 0, 0};
        vecs[7] = '{8'h0A, 0, 0, 0, 8'h00, 1, 0};

        rst_n = 1'b0;
        drive(0, 8'h00, 0);
        zwatch = 0; zseen = 0;
        wr_s = 0; wr_w = 0; full_cnt_w = 0; full_cnt_s = 0; last_addr_s = '0;
        #12;
        expect_eq("rst_we", int'(bus_s.o_we), 0);
        expect_eq("rst_addr", int'(bus_s.o_address), 0);
        expect_eq("rst_data", int'(bus_s.o_data), 0);
        expect_eq("rst_ready", int'(bus_s.o_ready | bus_w.o_ready), 0);
        expect_eq("rst_scroll", int'(scr_s), 0);
        expect_eq("rst_cursor", int'({row_s, col_s}), 0);
        expect_eq("rst_full", int'(full_s | full_w), 0);
        expect_eq("rst_wrap_we", int'(bus_w.o_we), 0);

        model_reset(0);
        model_reset(1);
        @(negedge clk);
        rst_n = 1'b1;

        wait_ready("reset_clear", low);
        expect_eq("reset_clear_low_cycles", low, ROWS * COLS);
        expect_eq("reset_clear_writes", wr_s, ROWS * COLS);
        expect_eq("reset_clear_last_addr", int'(last_addr_s), {5'd29, 7'd79});

        for (int v = 0; v < 8; v++) begin
            drive(1, vecs[v].d, 0);
            tick();
            expect_eq($sformatf("vec%0d_we", v), int'(bus_s.o_we), int'(vecs[v].we));
            if (vecs[v].we) begin
                expect_eq($sformatf("vec%0d_addr", v), int'(bus_s.o_address),
                          (vecs[v].row << 7) | vecs[v].col);
                expect_eq($sformatf("vec%0d_data", v), int'(bus_s.o_data), int'(vecs[v].wd));
            end
            expect_eq($sformatf("vec%0d_cursor", v), (int'(row_s) << 7) | int'(col_s),
                      (vecs[v].cr << 7) | vecs[v].cc);
        end
        drive(0, 8'h00, 0);

        do_clear();
        wr_s = 0;
        for (int i = 0; i < 81; i++) begin
            drive(1, 8'h78, 0);
            tick();
            if (i == 79) expect_eq("x80_addr", int'(bus_s.o_address), {5'd0, 7'd79});
        end
        expect_eq("x81_addr", int'(bus_s.o_address), {5'd1, 7'd0});
        expect_eq("x81_writes", wr_s, 81);
        expect_eq("x81_cursor", (int'(row_s) << 7) | int'(col_s), (1 << 7) | 1);
        drive(1, 8'h08, 0);
        tick();
        expect_eq("bs1_we", int'(bus_s.o_we), 1);
        expect_eq("bs1_addr_data", int'({bus_s.o_address, bus_s.o_data}), int'({5'd1, 7'd0, 8'h20}));
        expect_eq("bs1_cursor", (int'(row_s) << 7) | int'(col_s), 1 << 7);
        tick();
        expect_eq("bs2_we", int'(bus_s.o_we), 0);
        drive(0, 8'h00, 0);

        do_clear();
        for (int i = 0; i < 29; i++) begin
            drive(1, 8'h0A, 0);
            tick();
        end
        expect_eq("lf29_row", int'(row_s), 29);
        full_cnt_w = 0; full_cnt_s = 0;
        tick();
        drive(0, 8'h00, 0);
        expect_eq("lf30_scroll_s", int'(scr_s), 1);
        expect_eq("lf30_scroll_w", int'(scr_w), 0);
        expect_eq("lf30_row_s", int'(row_s), 0);
        expect_eq("lf30_row_w", int'(row_w), 0);
        wr_s = 0; wr_w = 0;
        wait_ready("clear_line", low);
        expect_eq("clear_line_low", low, COLS);
        expect_eq("clear_line_writes_s", wr_s, COLS);
        expect_eq("clear_line_writes_w", wr_w, COLS);
        expect_eq("full_pulses_w", full_cnt_w, 1);
        expect_eq("full_pulses_s", full_cnt_s, 0);

        drive(1, 8'h0A, 0);
        tick();
        expect_eq("lf_bottom_ready", int'(bus_s.o_ready), 0);
        drive(1, 8'h5A, 0);
        zwatch = 1;
        wait_ready("z_clear_line", low);
        drive(1, 8'h5A, 1);
        tick();
        drive(0, 8'h00, 0);
        expect_eq("clr_scroll", int'(scr_s), 0);
        expect_eq("clr_cursor", (int'(row_s) << 7) | int'(col_s), 0);
        expect_eq("clr_ready", int'(bus_s.o_ready), 0);
        wr_s = 0;
        for (int g = 0; g < 10 && wr_s == 0; g++) tick();
        expect_eq("clr_first_addr", int'({bus_s.o_address, bus_s.o_data}), int'({12'd0, 8'h20}));
        wait_ready("clr_restart", low);
        expect_eq("z_never_written", int'(zseen), 0);
        zwatch = 0;

        for (int c = 0; c < 4000; c++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r < 4)       dat = 8'h0A;
            else if (r == 4) dat = 8'h0D;
            else if (r == 5) dat = 8'h08;
            else if (r == 6) dat = 8'($urandom_range(0, 255));
            else             dat = 8'($urandom_range(32, 126));
            vld = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 1999) == 0);
            tick();
        end
        drive(0, 8'h00, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
